// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the MEM-stage data memory controller.
//   - access size codes (size field of a request)
//   - controller state encoding
//   - misalignment helper used when a request is accepted
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } dmem_state_t;

    // Size code 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic w_mis;
        case (size)
            SZ_BYTE: w_mis = 1'b0;
            SZ_HALF: w_mis = addr_lo[0];
            default: w_mis = (addr_lo != 2'b00);
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational lane steering for little-endian byte/half/word access.
// Ports:
//   i_old_word   current contents of the addressed memory word
//   i_addr_lo    byte offset within the word
//   i_size       access size code
//   i_unsigned   1: zero-extend loads, 0: sign-extend loads
//   i_wdata      store data (low bytes used for byte/half stores)
//   o_byte_mask  lanes written by a store
//   o_merged     old word with the written lanes replaced
//   o_load_data  selected lane shifted to bit 0 and extended
// ----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_byte_mask,
    output logic [31:0] o_merged,
    output logic [31:0] o_load_data
);

    logic [31:0] w_rep;
    logic [31:0] w_shift;

    always_comb begin
        o_byte_mask = 4'b1111;
        w_rep       = i_wdata;
        w_shift     = i_old_word;
        o_load_data = i_old_word;
        case (i_size)
            SZ_BYTE: begin
                o_byte_mask = 4'b0001 << i_addr_lo;
                w_rep       = {4{i_wdata[7:0]}};
                w_shift     = i_old_word >> {i_addr_lo, 3'b000};
                o_load_data = i_unsigned ? {24'd0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
            end
            SZ_HALF: begin
                // addr bit 0 is never set here on a committed access
                o_byte_mask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                w_rep       = {2{i_wdata[15:0]}};
                w_shift     = i_old_word >> {i_addr_lo[1], 4'b0000};
                o_load_data = i_unsigned ? {16'd0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
            end
            default: begin
                o_byte_mask = 4'b1111;
                w_rep       = i_wdata;
                w_shift     = i_old_word;
                o_load_data = i_old_word;
            end
        endcase
    end

    // The store data is replicated across lanes so each masked lane simply
    // picks its own byte position.
    always_comb begin
        o_merged = i_old_word;
        for (int i = 0; i < 4; i++) begin
            if (o_byte_mask[i]) begin
                o_merged[8*i +: 8] = w_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// ----------------------------------------------------------------------------
// data_memory_ctrl
// Multi-cycle data memory for the MEM stage: request/stall handshake,
// configurable latency, byte/half/word access with extension, misalignment
// detection. One access in flight at a time.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a request; accepts req with read or write set
//   BUSY    | access in progress; r_cnt counts remaining busy cycles
//   DONE    | completion cycle; done_o pulses, stall_o low, req ignored
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   req_i        access request
//   memread_i    load access
//   memwrite_i   store access (wins when both are set)
//   size_i       00 byte, 01 half, 10/11 word
//   unsigned_i   load extension: 1 zero, 0 sign
//   addr_i       byte address
//   writedata_i  store data
//   readdata_o   registered load result
//   stall_o      pipeline stall request
//   done_o       one-cycle completion pulse
//   misalign_o   misaligned access flag, valid with done_o
// ----------------------------------------------------------------------------
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       writedata_i,
    output logic [31:0]       readdata_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              misalign_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    dmem_state_t        r_state;
    dmem_state_t        w_state_nx;
    logic [CW-1:0]      r_cnt;
    logic [AW+1:0]      r_addr;
    logic [31:0]        r_wdata;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic               r_write;
    logic               r_misalign;
    logic [31:0]        r_readdata;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_misalign;
    logic               w_commit;
    logic               w_stall;
    logic [AW-1:0]      w_idx;
    logic [31:0]        w_old_word;
    logic [3:0]         w_byte_mask;
    logic [31:0]        w_merged;
    logic [31:0]        w_load_data;

    // Upper address bits only select aliases of the same word.
    generate
        if (ADDR_W > AW + 2) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^addr_i[ADDR_W-1:AW+2];
        end
    endgenerate

    assign w_misalign = is_misaligned(size_i, addr_i[1:0]);
    assign w_idx      = r_addr[AW+1:2];
    assign w_old_word = r_mem[w_idx];

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_commit   = 1'b0;
        w_stall    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_i && (memread_i || memwrite_i)) begin
                    w_accept   = 1'b1;
                    w_stall    = 1'b1;
                    w_state_nx = w_misalign ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_commit   = 1'b1;
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= SZ_WORD;
            r_unsigned <= 1'b0;
            r_write    <= 1'b0;
            r_misalign <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_addr     <= addr_i[AW+1:0];
                r_wdata    <= writedata_i;
                r_size     <= size_i;
                r_unsigned <= unsigned_i;
                r_write    <= memwrite_i;
                r_misalign <= w_misalign;
                r_cnt      <= CW'(LATENCY);
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_commit && !r_write) begin
                r_readdata <= w_load_data;
            end
        end
    end

    // Storage has no reset; a reset during BUSY suppresses the commit.
    always_ff @(posedge clk_i) begin
        if (rst_i && w_commit && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_merged[8*i +: 8];
                end
            end
        end
    end

    dmem_lane_align u_lane_align (
        .i_old_word  (w_old_word),
        .i_addr_lo   (r_addr[1:0]),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_wdata     (r_wdata),
        .o_byte_mask (w_byte_mask),
        .o_merged    (w_merged),
        .o_load_data (w_load_data)
    );

    assign readdata_o = r_readdata;
    assign stall_o    = rst_i && w_stall;
    assign done_o     = (r_state == ST_DONE);
    assign misalign_o = (r_state == ST_DONE) && r_misalign;

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, multi-cycle data memory for the pipelined CPU's MEM stage. It replaces the zero-latency, word-only, combinationally written data memory. It adds a request/stall handshake, a configurable access latency, byte/half/word accesses with sign or zero extension, and misalignment detection. Writes are clocked, and exactly one access is in flight at a time.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 2.
LATENCY, 2, number of BUSY cycles per aligned access; at least 1.
ADDR_W, 32, width of the byte address input.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset; synchronous, active-low.
req_i  in  1  access request from the MEM stage.
memread_i  in  1  load access.
memwrite_i  in  1  store access.
size_i  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
unsigned_i  in  1  load extension: 1 zero-extend, 0 sign-extend.
addr_i  in  ADDR_W  byte address.
writedata_i  in  32  store data, taken from the low bytes for byte and half stores.
readdata_o  out  32  load result, extended to 32 bits; registered.
stall_o  out  1  pipeline stall request.
done_o  out  1  one-cycle pulse marking access completion.
misalign_o  out  1  error flag, valid while done_o is high.

Behaviour:
- States:
  - IDLE: waiting for a request.
  - BUSY: access in progress; holds a down-counter of width clog2(LATENCY+1).
  - DONE: completion cycle.
- Request acceptance:
  - A request is accepted only in IDLE, when req_i=1 and (memread_i or memwrite_i)=1.
  - If memread_i and memwrite_i are both 1, the access is a write.
  - A request with neither set is ignored and no stall is raised.
- Latching on accept (cycle T): addr, writedata, size, unsigned and the read/write type are captured into internal registers.
- Misalignment check:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
  - A misaligned access goes to DONE at T+1 with misalign_o=1.
  - No memory write occurs and readdata_o is left unchanged.
- Aligned access timing:
  - BUSY occupies cycles T+1 through T+LATENCY.
  - DONE occurs at T+LATENCY+1.
  - The memory write or read commits on the BUSY-to-DONE edge.
- Word index: addr[clog2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4 bytes.
- Byte and half writes modify only the addressed lanes, little-endian:
  - byte lane = addr[1:0]
  - half lane = addr[1]
- Loads:
  - The selected lane is shifted to bit 0, then extended according to the latched unsigned flag.
  - readdata_o updates only on a load commit and holds its value otherwise, including across stores.
- stall_o (combinational) = (IDLE and request accepted) or BUSY. It is low in DONE so the pipeline advances in that cycle.
- DONE:
  - done_o=1 for exactly one cycle.
  - The next state is always IDLE.
  - req_i is ignored in DONE, so back-to-back accesses are separated by at least one IDLE cycle.
- Reset (rst_i=0 at a rising edge):
  - Forces IDLE.
  - readdata_o=0, done_o=0, misalign_o=0; stall_o is forced to 0 while rst_i=0.
  - A pending access is aborted and no write commits.
  - Memory contents are not cleared.
- Inputs may change after acceptance; only the latched values are used.

Decomposition:
- Shared package (dmem_pkg):
  - Size codes SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum ST_IDLE, ST_BUSY, ST_DONE.
- One sub-module, dmem_lane_align, purely combinational:
  - Computes the write byte mask and merged write word.
  - Computes the extended load data from the old word, the latched address low bits, size and unsigned flag.
- The FSM, counter and storage array stay in data_memory_ctrl.

Test Plan:
1. Reset, then store word 0xDEADBEEF at addr 0x10 and load word 0x10 with LATENCY=2 -> stall_o high for 3 cycles, done_o pulses at T+3, readdata_o=0xDEADBEEF, misalign_o=0.
2. Store byte 0x80 at addr 0x11 over 0x00000000, then load the byte signed and unsigned -> word becomes 0x00008000; signed load returns 0xFFFFFF80, unsigned load returns 0x00000080.
3. Store half 0x1234 at addr 0x16, then load word 0x14 -> returns 0x12340000 (prior contents 0).
4. Load word at addr 0x13 -> done_o at T+1, misalign_o=1, readdata_o unchanged, memory unchanged on readback.
5. Store word 0xA5A5A5A5 to addr 0x20, assert rst_i=0 during the first BUSY cycle, then load 0x20 -> returns the old value (write aborted); all outputs 0 after reset.
6. DEPTH_WORDS=8: store 0x11 to addr 0x00, then load word 0x20 -> returns 0x00000011 (wrap); req_i held high through DONE -> second access accepted only in the following IDLE cycle.
